// File: rtl/conv_accumulator_pkg.sv
// Shared definitions for the convolution window accumulator.
//   state_t       : accumulator FSM states (idle, accumulating, result held)
//   DATA_W        : data path width (fixed at 16 in this revision)
//   KLEN_DEFAULT  : default number of partial products per window
package conv_accumulator_pkg;

  localparam int unsigned DATA_W       = 16;
  localparam int unsigned KLEN_DEFAULT = 9;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAcc  = 2'd1,
    StDone = 2'd2
  } state_t;

endpackage

// File: rtl/conv_accumulator_csa.sv
// 16-bit carry-select adder.
//   x, y : addends
//   sum  : x + y modulo 2^16
//   cout : carry out of bit 15
// The low byte ripples; the high byte is computed for both carry-in values
// and the low-byte carry selects the correct result.
module CSA_16BIT (
  input  logic [15:0] x,
  input  logic [15:0] y,
  output logic [15:0] sum,
  output logic        cout
);

  logic [8:0] lo;
  logic [8:0] hi_c0;
  logic [8:0] hi_c1;

  always_comb begin
    lo    = {1'b0, x[7:0]} + {1'b0, y[7:0]};
    hi_c0 = {1'b0, x[15:8]} + {1'b0, y[15:8]};
    hi_c1 = {1'b0, x[15:8]} + {1'b0, y[15:8]} + 9'd1;
    if (lo[8]) begin
      sum  = {hi_c1[7:0], lo[7:0]};
      cout = hi_c1[8];
    end else begin
      sum  = {hi_c0[7:0], lo[7:0]};
      cout = hi_c0[8];
    end
  end

endmodule

// File: rtl/conv_accumulator.sv
// Convolution window accumulator: sums KLEN signed partial products per
// window and presents the wrapped sum plus a sticky signed-overflow flag.
//   clk, rst_n          : clock (rising edge), async active-low reset
//   clr                 : synchronous window abort (beats priority over handshakes)
//   in_valid/in_ready   : input handshake, in_data is a signed partial product
//   out_valid/out_ready : output handshake for out_data/out_ovf
module conv_accumulator
  import conv_accumulator_pkg::*;
#(
  parameter int unsigned KLEN = KLEN_DEFAULT,
  parameter int unsigned DW   = DATA_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_ovf
);

  localparam int unsigned CW = $clog2(KLEN + 1);

  state_t        state_q, state_d;
  logic [DW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  // Holds in_ready low until the first clock after reset release.
  logic          live_q;

  logic [DW-1:0] add_sum;
  logic          add_ovf;
  logic [CW-1:0] cnt_inc;
  logic          in_hs;
  logic          out_hs;

  CSA_16BIT u_adder (
    .x    (acc_q),
    .y    (in_data),
    .sum  (add_sum),
    .cout ()
  );

  // Signed overflow: operands agree in sign, sum disagrees.
  assign add_ovf = (acc_q[DW-1] == in_data[DW-1]) && (add_sum[DW-1] != acc_q[DW-1]);
  assign cnt_inc = cnt_q + CW'(1);

  always_comb begin
    in_ready  = live_q && (state_q != StDone);
    out_valid = (state_q == StDone);
    out_data  = acc_q;
    out_ovf   = ovf_q;
  end

  assign in_hs  = in_valid && in_ready;
  assign out_hs = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    if (clr) begin
      state_d = StIdle;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_hs) begin
            acc_d   = in_data;
            cnt_d   = CW'(1);
            ovf_d   = 1'b0;
            state_d = (KLEN == 1) ? StDone : StAcc;
          end
        end
        StAcc: begin
          if (in_hs) begin
            acc_d = add_sum;
            cnt_d = cnt_inc;
            ovf_d = ovf_q | add_ovf;
            if (cnt_inc == CW'(KLEN)) begin
              state_d = StDone;
            end
          end
        end
        StDone: begin
          if (out_hs) begin
            state_d = StIdle;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      live_q  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_conv_accumulator.sv
module tb_conv_accumulator;

  localparam int KLEN = 9;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_ovf;

  int total = 0;
  int bad   = 0;

  typedef logic [15:0] win_t [KLEN];
  typedef struct {
    string       name;
    win_t        d;
    bit          bub;
    logic [15:0] exp_d;
    logic        exp_o;
  } vec_t;

  vec_t vecs [5];

  conv_accumulator #(.KLEN(KLEN), .DW(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Reference: signed integer sum, overflow whenever an intermediate add
  // leaves the 16-bit signed range, result wrapped back to 16 bits.
  task automatic model(input win_t d, output logic [15:0] s, output logic o);
    int acc;
    int t;
    logic [31:0] tv;
    logic signed [15:0] w;
    w   = d[0];
    acc = w;
    o   = 1'b0;
    for (int i = 1; i < KLEN; i++) begin
      w  = d[i];
      t  = acc + int'(w);
      if (t > 32767 || t < -32768) o = 1'b1;
      tv  = t;
      w   = tv[15:0];
      acc = w;
    end
    tv = acc;
    s  = tv[15:0];
  endtask

  task automatic put(input logic [15:0] d);
    @(negedge clk);
    chk("in_ready before beat", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_data = 16'($urandom);
    end
  endtask

  task automatic run_window(input string nm, input win_t d, input bit bub,
                            input logic [15:0] ed, input logic eo);
    out_ready = 1'b1;
    for (int i = 0; i < KLEN; i++) begin
      if (bub) idle($urandom_range(0, 2));
      put(d[i]);
      if (i < KLEN - 1) begin
        chk({nm, " early out_valid"}, {31'd0, out_valid}, 32'd0);
      end else begin
        chk({nm, " out_valid"}, {31'd0, out_valid}, 32'd1);
        chk({nm, " out_data"}, {16'd0, out_data}, {16'd0, ed});
        chk({nm, " out_ovf"}, {31'd0, out_ovf}, {31'd0, eo});
      end
    end
    @(posedge clk);
    #1;
    chk({nm, " consumed"}, {31'd0, out_valid}, 32'd0);
    chk({nm, " in_ready after"}, {31'd0, in_ready}, 32'd1);
    out_ready = 1'b0;
  endtask

  initial begin
    win_t        w;
    logic [15:0] es;
    logic        eo;

    rst_n     = 1'b0;
    clr       = 1'b0;
    in_valid  = 1'b0;
    in_data   = 16'd0;
    out_ready = 1'b0;

    // Reset state
    #2;
    chk("reset in_ready", {31'd0, in_ready}, 32'd0);
    chk("reset out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset out_data", {16'd0, out_data}, 32'd0);
    chk("reset out_ovf", {31'd0, out_ovf}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("in_ready before first clk", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    chk("in_ready first clk", {31'd0, in_ready}, 32'd1);

    // Directed table
    vecs[0].name = "seq1to9";
    vecs[0].d = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9};
    vecs[0].bub = 1'b0; vecs[0].exp_d = 16'h002D; vecs[0].exp_o = 1'b0;
    vecs[1].name = "nine4000";
    vecs[1].d = '{default: 16'h4000};
    vecs[1].bub = 1'b0; vecs[1].exp_d = 16'h4000; vecs[1].exp_o = 1'b1;
    vecs[2].name = "mixed bubbles";
    vecs[2].d = '{16'hFFFD, 16'd2, 16'hFFFD, 16'd2, 16'hFFFD, 16'd2, 16'hFFFD, 16'd2, 16'hFFFD};
    vecs[2].bub = 1'b1; vecs[2].exp_d = 16'hFFF9; vecs[2].exp_o = 1'b0;
    vecs[3].name = "neg overflow";
    vecs[3].d = '{16'h8000, 16'hFFFF, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    vecs[3].bub = 1'b0; vecs[3].exp_d = 16'h7FFF; vecs[3].exp_o = 1'b1;
    vecs[4].name = "zeros";
    vecs[4].d = '{default: 16'd0};
    vecs[4].bub = 1'b1; vecs[4].exp_d = 16'h0000; vecs[4].exp_o = 1'b0;

    for (int v = 0; v < 5; v++) begin
      run_window(vecs[v].name, vecs[v].d, vecs[v].bub, vecs[v].exp_d, vecs[v].exp_o);
    end

    // Backpressure: result held, extra beats ignored
    out_ready = 1'b0;
    for (int i = 0; i < KLEN; i++) put(16'(10 + i));
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 16'h1234;
      @(posedge clk);
      #1;
      chk("bp out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp out_data", {16'd0, out_data}, 32'd126);
      chk("bp in_ready", {31'd0, in_ready}, 32'd0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("bp released out_valid", {31'd0, out_valid}, 32'd0);
    chk("bp released in_ready", {31'd0, in_ready}, 32'd1);

    // clr after four beats, together with a beat that must be dropped
    for (int i = 0; i < 4; i++) put(16'd7);
    @(negedge clk);
    clr      = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'd7;
    @(posedge clk);
    #1;
    clr      = 1'b0;
    in_valid = 1'b0;
    chk("clr out_valid", {31'd0, out_valid}, 32'd0);
    w = '{default: 16'd1};
    run_window("after clr", w, 1'b0, 16'd9, 1'b0);

    // clr with a simultaneous output handshake
    out_ready = 1'b0;
    for (int i = 0; i < KLEN; i++) put(16'd5);
    chk("done before clr", {16'd0, out_data}, 32'd45);
    @(negedge clk);
    clr       = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    clr       = 1'b0;
    out_ready = 1'b0;
    chk("clr in done out_valid", {31'd0, out_valid}, 32'd0);
    chk("clr in done in_ready", {31'd0, in_ready}, 32'd1);

    // Reset mid-window
    for (int i = 0; i < 5; i++) put(16'd2);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid reset in_ready", {31'd0, in_ready}, 32'd0);
    chk("mid reset out_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post reset in_ready", {31'd0, in_ready}, 32'd1);
    w = '{default: 16'd2};
    run_window("after reset", w, 1'b0, 16'd18, 1'b0);

    // Randomised windows against the reference model
    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < KLEN; i++) begin
        w[i] = (r % 2 == 0) ? 16'($urandom) : 16'($urandom_range(0, 255) - 128);
      end
      model(w, es, eo);
      run_window($sformatf("rand%0d", r), w, 1'(r % 3 == 0), es, eo);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
